icache_2way: RTL and testbench
==============================

# icache_2way

Parametrised two-way set-associative instruction cache, successor to the fixed 64-byte direct-mapped icache. Sits between the core fetch stage and instruction memory. Serves hits with one registered read cycle and fills a whole line on a miss over a variable-latency `mreq`/`mem_ack` handshake. Adds per-set LRU replacement and a whole-cache flush.

## Interface
- `ADDR_W`, 10: word address width.
- `DATA_W`, 16: instruction width.
- `SETS`, 4: sets per way, power of two ≥2.
- `WORDS`, 8: words per line, power of two ≥2.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clk_en` in 1: global enable; low freezes all state.
- `req` in 1: fetch request.
- `flush` in 1: invalidate whole cache.
- `address_in` in ADDR_W: fetch word address; held stable by the core while `busy`.
- `from_mem` in DATA_W: fill data, valid when `mem_ack`.
- `mem_ack` in 1: memory accepted `address_out`, and `from_mem` holds that word.
- `inst_out` out DATA_W: fetched instruction, registered.
- `inst_valid` out 1: `inst_out` holds a hit result.
- `address_out` out ADDR_W: fill word address.
- `busy` out 1: stall core.
- `mreq` out 1: fill request.

## Operation
- Address split: offset = low log2(WORDS) bits; index = next log2(SETS) bits; tag = remaining bits.
- Storage per way: data array SETS×WORDS, tag plus valid bit per set. One LRU bit per set, pointing at the way to evict.
- Hit: `req`, and some way's valid bit is set with matching tag at index. Miss: `req` and no hit.
- States: IDLE, FILL, DONE.
- IDLE, `flush`=1: clear all valid and LRU bits. No lookup; `inst_valid`←0. Flush has priority over `req`.
- IDLE, hit: `inst_out`←hit word, `inst_valid`←1, LRU[index]←other way.
- IDLE, miss: `inst_valid`←0, pick victim, `cnt`←0, go to FILL.
- IDLE, no `req`: `inst_valid`←0.
- Victim choice: invalid way 0 first, else invalid way 1, else LRU[index]. Store the victim in a register at miss.
- FILL: `mreq`=1, `address_out`={tag, index, cnt}.
  - On `mem_ack`: write `from_mem` to victim[index][cnt], `cnt`++.
  - On ack with `cnt`=WORDS−1: write victim tag, set its valid bit, LRU[index]←other way, go to DONE.
  - Victim valid bit is cleared on entry to FILL, so a partial line is never visible.
- DONE: one cycle, then IDLE. The held address is re-looked-up in IDLE and hits.
- `flush` in FILL/DONE: latched as pending; no abort. Applied on the first IDLE cycle, with the same priority as a live flush, so the filled line is also discarded.
- `clk_en`=0: no state, array, counter or output-register update. `mreq`, `busy` forced 0. `mem_ack` ignored.
- Reset (asynchronous): all valid bits 0, LRU 0, state IDLE, `cnt` 0, pending flush 0, `inst_out` 0, `inst_valid` 0. Data arrays are not reset.
- Reset mid-fill: fill abandoned, line stays invalid. `mreq` drops immediately.

## Timing
- Combinational outputs:
  - `busy` = `clk_en` & (state≠IDLE | (IDLE & miss & !flush & !pending)).
  - `mreq` = `clk_en` & (state==FILL).
  - `address_out` = {tag, index, cnt}, meaningful only while `mreq`.
- Hit latency: `inst_out`/`inst_valid` are valid one cycle after the lookup cycle.
- Miss with `mem_ack` tied high, lookup at cycle T:
  - `busy` high T..T+WORDS+1.
  - `mreq` high T+1..T+WORDS.
  - IDLE re-lookup at T+WORDS+2; `inst_valid`=1 at T+WORDS+3.
- Every `mem_ack` gap adds one stall cycle. `mem_ack` outside FILL is ignored.
- Back-to-back hits: one result per cycle, no bubbles.

## Test plan
- Reset, then `req` at 0x000 -> miss; `mreq` 8 cycles with `address_out` 0x000..0x007; `busy` 10 cycles; `inst_out`=mem[0x000], `inst_valid`=1 at cycle 11.
- After fill, `req` 0x001..0x007 on consecutive cycles -> 7 hits, no `busy`, `inst_out` = mem words in order.
- Lines 0x000, 0x020 (same set 0), hit 0x000, then miss 0x040 -> way holding 0x020 evicted. Re-request 0x000 hits; 0x020 misses.
- `mem_ack` toggling 1,0,1,0 during fill -> `busy` length 2+2·8−1; data written only on ack cycles; line correct.
- `flush` asserted at FILL cycle 3 -> fill completes, first IDLE flushes, re-lookup of same address misses again.
- `clk_en` low for 5 cycles mid-fill -> `mreq`/`busy` 0, `cnt` frozen. Resumes at same `address_out`; `rst_n` pulse mid-fill -> all outputs 0, next `req` misses.

Source files
------------

// File: rtl/icache_2way_if.sv
// Fetch-side and memory-side signals of the two-way instruction cache.
// The slave modport is the cache view; the master modport is the core/memory environment view.
interface icache_2way_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16
);
    logic              req;
    logic              flush;
    logic [ADDR_W-1:0] address_in;
    logic [DATA_W-1:0] from_mem;
    logic              mem_ack;
    logic [DATA_W-1:0] inst_out;
    logic              inst_valid;
    logic [ADDR_W-1:0] address_out;
    logic              busy;
    logic              mreq;

    modport master (
        output req, flush, address_in, from_mem, mem_ack,
        input  inst_out, inst_valid, address_out, busy, mreq
    );

    modport slave (
        input  req, flush, address_in, from_mem, mem_ack,
        output inst_out, inst_valid, address_out, busy, mreq
    );
endinterface

// File: rtl/icache_2way.sv
// Two-way set-associative instruction cache with per-set LRU replacement, whole-line fill over a
// variable-latency ack handshake, and a whole-cache flush that is deferred while a fill runs.
module icache_2way #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SETS   = 4,
    parameter int unsigned WORDS  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_en,
    icache_2way_if.slave  bus
);
    localparam int unsigned OFF_W = $clog2(WORDS);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int unsigned LINES = SETS * WORDS;

    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;

    assign off = bus.address_in[OFF_W-1:0];
    assign idx = bus.address_in[OFF_W +: IDX_W];
    assign tag = bus.address_in[ADDR_W-1 -: TAG_W];

    // Data and tags are qualified by the valid bits, so they carry no reset.
    logic [DATA_W-1:0] data_q [2][LINES];
    logic [TAG_W-1:0]  tag_q  [2][SETS];

    logic [1:0][SETS-1:0] valid_q, valid_d;
    logic [SETS-1:0]      lru_q, lru_d;
    state_e               state_q, state_d;
    logic [OFF_W-1:0]     cnt_q, cnt_d;
    logic                 victim_q, victim_d;
    logic                 pend_q, pend_d;
    logic [DATA_W-1:0]    inst_out_q, inst_out_d;
    logic                 inst_valid_q, inst_valid_d;

    logic              hit0, hit1, hit, miss;
    logic              data_we, tag_we;
    logic [DATA_W-1:0] hit_word;

    assign hit0     = valid_q[0][idx] && (tag_q[0][idx] == tag);
    assign hit1     = valid_q[1][idx] && (tag_q[1][idx] == tag);
    assign hit      = hit0 || hit1;
    assign miss     = bus.req && !hit;
    assign hit_word = hit0 ? data_q[0][{idx, off}] : data_q[1][{idx, off}];

    assign bus.busy        = clk_en && ((state_q != StIdle) || (miss && !bus.flush && !pend_q));
    assign bus.mreq        = clk_en && (state_q == StFill);
    assign bus.address_out = {tag, idx, cnt_q};
    assign bus.inst_out    = inst_out_q;
    assign bus.inst_valid  = inst_valid_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        lru_d        = lru_q;
        cnt_d        = cnt_q;
        victim_d     = victim_q;
        pend_d       = pend_q;
        inst_out_d   = inst_out_q;
        inst_valid_d = inst_valid_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.flush || pend_q) begin
                    valid_d      = '0;
                    lru_d        = '0;
                    pend_d       = 1'b0;
                    inst_valid_d = 1'b0;
                end else if (bus.req && hit) begin
                    inst_out_d   = hit_word;
                    inst_valid_d = 1'b1;
                    lru_d[idx]   = hit0 ? 1'b1 : 1'b0;
                end else if (bus.req) begin
                    inst_valid_d = 1'b0;
                    if (!valid_q[0][idx]) begin
                        victim_d = 1'b0;
                    end else if (!valid_q[1][idx]) begin
                        victim_d = 1'b1;
                    end else begin
                        victim_d = lru_q[idx];
                    end
                    // Invalidate now so a half-written line can never hit.
                    valid_d[victim_d][idx] = 1'b0;
                    cnt_d   = '0;
                    state_d = StFill;
                end else begin
                    inst_valid_d = 1'b0;
                end
            end
            StFill: begin
                if (bus.flush) begin
                    pend_d = 1'b1;
                end
                if (bus.mem_ack) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == OFF_W'(WORDS - 1)) begin
                        tag_we                 = 1'b1;
                        valid_d[victim_q][idx] = 1'b1;
                        lru_d[idx]             = ~victim_q;
                        state_d                = StDone;
                    end
                end
            end
            StDone: begin
                if (bus.flush) begin
                    pend_d = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            valid_q      <= '0;
            lru_q        <= '0;
            cnt_q        <= '0;
            victim_q     <= 1'b0;
            pend_q       <= 1'b0;
            inst_out_q   <= '0;
            inst_valid_q <= 1'b0;
        end else if (clk_en) begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            lru_q        <= lru_d;
            cnt_q        <= cnt_d;
            victim_q     <= victim_d;
            pend_q       <= pend_d;
            inst_out_q   <= inst_out_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en && data_we) begin
            data_q[victim_q][{idx, cnt_q}] <= bus.from_mem;
        end
        if (clk_en && tag_we) begin
            tag_q[victim_q][idx] <= tag;
        end
    end
endmodule

// File: tb/tb_icache_2way.sv
// Directed bench for icache_2way: fills, hits, LRU eviction, ack gaps, deferred flush,
// clock-enable freeze and reset during a fill, each checked against hand-derived values.
module tb_icache_2way;
    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 16;
    localparam int unsigned SETS  = 4;
    localparam int unsigned WORDS = 8;

    logic clk;
    logic rst_n;
    logic clk_en;
    int   n_chk;
    int   n_fail;

    icache_2way_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    icache_2way #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .SETS  (SETS),
        .WORDS (WORDS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clk_en(clk_en),
        .bus   (bus)
    );

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return 16'h5A00 ^ ({6'd0, a} * 16'd37);
    endfunction

    // Garbage on non-ack cycles exposes writes that ignore mem_ack.
    assign bus.from_mem = bus.mem_ack ? mem_fn(bus.address_out) : 16'hDEAD;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic do_hit(input logic [AW-1:0] a);
        bus.req        = 1'b1;
        bus.address_in = a;
        #1;
        chk("hit_busy", 32'(bus.busy), 0);
        cyc();
        chk("hit_valid", 32'(bus.inst_valid), 1);
        chk("hit_data", 32'(bus.inst_out), 32'(mem_fn(a)));
    endtask

    // Full miss with mem_ack tied high: lookup, WORDS fill cycles, DONE, re-lookup, result.
    task automatic do_miss(input logic [AW-1:0] a);
        bus.req        = 1'b1;
        bus.address_in = a;
        bus.mem_ack    = 1'b1;
        #1;
        chk("miss_busy", 32'(bus.busy), 1);
        chk("miss_mreq", 32'(bus.mreq), 0);
        cyc();
        for (int i = 0; i < WORDS; i++) begin
            chk("fill_mreq", 32'(bus.mreq), 1);
            chk("fill_addr", 32'(bus.address_out), 32'((a & ~10'h7) | 10'(i)));
            cyc();
        end
        chk("done_busy", 32'(bus.busy), 1);
        chk("done_mreq", 32'(bus.mreq), 0);
        cyc();
        chk("relook_busy", 32'(bus.busy), 0);
        cyc();
        chk("fill_valid", 32'(bus.inst_valid), 1);
        chk("fill_data", 32'(bus.inst_out), 32'(mem_fn(a)));
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        int busy_n;
        int acks;
        n_chk          = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        clk_en         = 1'b1;
        bus.req        = 1'b0;
        bus.flush      = 1'b0;
        bus.mem_ack    = 1'b0;
        bus.address_in = '0;
        #12;
        chk("rst_inst_out", 32'(bus.inst_out), 0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_mreq", 32'(bus.mreq), 0);
        rst_n = 1'b1;
        cyc();

        // Cold miss on line 0, then the rest of the line back to back.
        do_miss(10'h000);
        for (int i = 1; i < WORDS; i++) begin
            do_hit(10'(i));
        end
        bus.req = 1'b0;
        cyc();
        chk("idle_valid", 32'(bus.inst_valid), 0);

        // Set 0: 0x000 in way 0, 0x020 in way 1; touch 0x000 so 0x020 is evicted by 0x040.
        do_miss(10'h020);
        do_hit(10'h000);
        do_miss(10'h040);
        do_hit(10'h000);
        do_miss(10'h020);

        // Alternating ack: first fill cycle acks, then every other cycle.
        bus.req        = 1'b1;
        bus.address_in = 10'h108;
        busy_n         = 0;
        acks           = 0;
        for (int k = 0; k < 40; k++) begin
            bus.mem_ack = (k % 2 == 1);
            #1;
            if (!bus.busy) break;
            busy_n++;
            if (bus.mreq) begin
                chk("gap_addr", 32'(bus.address_out), 32'(10'h108 + 10'(acks)));
                if (bus.mem_ack) acks++;
            end
            cyc();
        end
        bus.mem_ack = 1'b0;
        chk("gap_busy_len", 32'(busy_n), 32'(2 + 2 * WORDS - 1));
        cyc();
        chk("gap_data", 32'(bus.inst_out), 32'(mem_fn(10'h108)));
        for (int i = 1; i < WORDS; i++) begin
            do_hit(10'(10'h108 + 10'(i)));
        end

        // Flush raised in the third fill cycle is deferred to the first IDLE cycle.
        bus.req        = 1'b1;
        bus.address_in = 10'h050;
        bus.mem_ack    = 1'b1;
        #1;
        cyc();
        for (int i = 1; i <= WORDS; i++) begin
            bus.flush = (i == 3);
            #1;
            chk("fl_mreq", 32'(bus.mreq), 1);
            cyc();
        end
        bus.flush = 1'b0;
        chk("fl_done_busy", 32'(bus.busy), 1);
        cyc();
        chk("fl_idle_busy", 32'(bus.busy), 0);
        cyc();
        chk("fl_idle_valid", 32'(bus.inst_valid), 0);
        do_miss(10'h050);
        do_miss(10'h000);

        // clk_en low for five cycles after three words have been filled.
        bus.req        = 1'b1;
        bus.address_in = 10'h0A8;
        bus.mem_ack    = 1'b1;
        #1;
        chk("en_miss_busy", 32'(bus.busy), 1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("en_addr", 32'(bus.address_out), 32'(10'h0A8 + 10'(i)));
            cyc();
        end
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("en_off_mreq", 32'(bus.mreq), 0);
            chk("en_off_busy", 32'(bus.busy), 0);
            cyc();
        end
        clk_en = 1'b1;
        #1;
        chk("en_resume_mreq", 32'(bus.mreq), 1);
        for (int i = 3; i < WORDS; i++) begin
            chk("en_addr2", 32'(bus.address_out), 32'(10'h0A8 + 10'(i)));
            cyc();
        end
        chk("en_done_busy", 32'(bus.busy), 1);
        cyc();
        chk("en_relook_busy", 32'(bus.busy), 0);
        cyc();
        chk("en_data", 32'(bus.inst_out), 32'(mem_fn(10'h0A8)));
        for (int i = 1; i < WORDS; i++) begin
            do_hit(10'(10'h0A8 + 10'(i)));
        end

        // Reset pulse three words into a fill; the line must stay invalid.
        bus.req        = 1'b1;
        bus.address_in = 10'h1F0;
        bus.mem_ack    = 1'b1;
        #1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
        end
        #2;
        bus.req = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("rr_mreq", 32'(bus.mreq), 0);
        chk("rr_busy", 32'(bus.busy), 0);
        chk("rr_inst_valid", 32'(bus.inst_valid), 0);
        chk("rr_inst_out", 32'(bus.inst_out), 0);
        #3;
        rst_n = 1'b1;
        cyc();
        do_miss(10'h1F0);
        bus.req = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
